// File: rtl/common.sv
// rtl/common.sv - shared fetch/decode types: REG_IF_ID, exception codes, fetch FSM states
package common;

  typedef enum logic [3:0] {
    INSTRUCTION_ADDRESS_MISALIGNED = 4'd0,
    INSTRUCTION_ACCESS_FAULT       = 4'd1,
    ILLEGAL_INSTRUCTION            = 4'd2,
    BREAKPOINT                     = 4'd3
  } exception_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] pcPlus4;
    logic [31:0] instr;
    logic [63:0] instrAddr;
    logic        exception_valid;
    exception_t  exception;
  } REG_IF_ID;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    READY = 2'd1,
    EXC   = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_sel.sv
// rtl/fetch_pc_sel.sv - next-pc priority mux: jump, branch, hold, sequential
module fetch_pc_sel (
  input  logic [63:0] pc_i,
  input  logic        jump_en_i,
  input  logic [63:0] jump_addr_i,
  input  logic        adopt_branch_i,
  input  logic [63:0] pcbranch_i,
  input  logic        hold_i,
  input  logic        step_i,
  output logic [63:0] next_pc_o,
  output logic        redirect_o
);

  always_comb begin
    next_pc_o  = pc_i;
    redirect_o = 1'b0;
    if (jump_en_i) begin
      next_pc_o  = jump_addr_i;
      redirect_o = 1'b1;
    end else if (adopt_branch_i) begin
      next_pc_o  = pcbranch_i;
      redirect_o = 1'b1;
    end else if (hold_i) begin
      next_pc_o = pc_i;
    end else if (step_i) begin
      next_pc_o = pc_i + 64'd4;
    end
  end

endmodule

// File: rtl/fetcher.sv
// rtl/fetcher.sv - instruction fetch stage feeding REG_IF_ID; FETCH_MISALIGN_CHECK_EN traps misaligned PCs
module fetcher
  import common::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_ok,
  input  logic [31:0] iresp_data,
  output REG_IF_ID    moduleOut,
  output logic        ok_to_proceed,
  input  logic        ok_to_proceed_overall,
  input  logic        lwHold,
  input  logic        JumpEn,
  input  logic [63:0] jumpAddr,
  input  logic        adopt_branch,
  input  logic [63:0] pcbranch
);

  fetch_state_t state_q;
  logic [63:0]  pc_q;
  logic [31:0]  ibuf_q;
  REG_IF_ID     out_q;
  logic [63:0]  next_pc;
  logic         redirect;
  logic         resp_hit;
  logic         load_misaligned;
  logic [31:0]  word;

  // Request is suppressed while reset is asserted so an abandoned response is never consumed.
  assign ireq_valid    = rst && (state_q == REQ);
  assign ireq_addr     = pc_q;
  assign resp_hit      = ireq_valid && iresp_ok;
  assign ok_to_proceed = (state_q == READY) || (state_q == EXC) || resp_hit;
  assign word          = (state_q == READY) ? ibuf_q : iresp_data;
  assign moduleOut     = out_q;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign load_misaligned = (next_pc[1:0] != 2'b00);
`else
  assign load_misaligned = 1'b0;
`endif

  fetch_pc_sel u_pc_sel (
    .pc_i           (pc_q),
    .jump_en_i      (JumpEn),
    .jump_addr_i    (jumpAddr),
    .adopt_branch_i (adopt_branch),
    .pcbranch_i     (pcbranch),
    .hold_i         (lwHold),
    .step_i         (ok_to_proceed && (state_q != EXC)),
    .next_pc_o      (next_pc),
    .redirect_o     (redirect)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      ibuf_q  <= 32'd0;
      out_q   <= '0;
    end else if (ok_to_proceed_overall) begin
      if (redirect) begin
        out_q.valid           <= 1'b0;
        out_q.exception_valid <= 1'b0;
        pc_q                  <= next_pc;
        state_q               <= load_misaligned ? EXC : REQ;
      end else if (lwHold) begin
        state_q <= state_q;
      end else if (ok_to_proceed) begin
`ifdef FETCH_MISALIGN_CHECK_EN
        if (state_q == EXC) begin
          out_q <= '{valid: 1'b1, pc: pc_q, pcPlus4: pc_q + 64'd4, instr: 32'd0,
                     instrAddr: pc_q, exception_valid: 1'b1,
                     exception: INSTRUCTION_ADDRESS_MISALIGNED};
        end else begin
`else
        begin
`endif
          out_q <= '{valid: 1'b1, pc: pc_q, pcPlus4: pc_q + 64'd4, instr: word,
                     instrAddr: pc_q, exception_valid: 1'b0,
                     exception: out_q.exception};
          pc_q    <= next_pc;
          state_q <= REQ;
        end
      end else begin
        out_q.valid <= 1'b0;
      end
    end else if (resp_hit) begin
      ibuf_q  <= iresp_data;
      state_q <= READY;
    end
  end

endmodule

// File: tb/tb_fetcher.sv
// tb/tb_fetcher.sv - self-checking bench for fetcher: vector table, reset corners, random vs reference model
module tb_fetcher;
  import common::*;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif
  localparam logic [63:0] RPC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_ok;
  logic [31:0] iresp_data;
  REG_IF_ID    moduleOut;
  logic        ok_to_proceed;
  logic        ok_to_proceed_overall;
  logic        lwHold;
  logic        JumpEn;
  logic [63:0] jumpAddr;
  logic        adopt_branch;
  logic [63:0] pcbranch;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetcher #(.RESET_PC(RPC)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .ireq_valid            (ireq_valid),
    .ireq_addr             (ireq_addr),
    .iresp_ok              (iresp_ok),
    .iresp_data            (iresp_data),
    .moduleOut             (moduleOut),
    .ok_to_proceed         (ok_to_proceed),
    .ok_to_proceed_overall (ok_to_proceed_overall),
    .lwHold                (lwHold),
    .JumpEn                (JumpEn),
    .jumpAddr              (jumpAddr),
    .adopt_branch          (adopt_branch),
    .pcbranch              (pcbranch)
  );

  typedef struct {
    bit          ovr, ok, jmp, br, hold;
    logic [63:0] ja, ba;
    bit          e_req;
    logic [63:0] e_addr;
    bit          e_ok, e_mv;
    logic [63:0] e_mpc;
    bit          e_exc;
  } vec_t;

  function automatic vec_t mk(bit ovr, bit ok, bit jmp, bit br, bit hold,
                              logic [63:0] ja, logic [63:0] ba,
                              bit e_req, logic [63:0] e_addr, bit e_ok,
                              bit e_mv, logic [63:0] e_mpc, bit e_exc);
    vec_t v;
    v.ovr = ovr; v.ok = ok; v.jmp = jmp; v.br = br; v.hold = hold;
    v.ja = ja; v.ba = ba; v.e_req = e_req; v.e_addr = e_addr; v.e_ok = e_ok;
    v.e_mv = e_mv; v.e_mpc = e_mpc; v.e_exc = e_exc;
    return v;
  endfunction

  function automatic logic [31:0] bus_word(logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(bit ovr, bit ok, bit jmp, bit br, bit hold,
                       logic [63:0] ja, logic [63:0] ba, logic [31:0] data);
    ok_to_proceed_overall = ovr;
    iresp_ok = ok;
    JumpEn = jmp;
    adopt_branch = br;
    lwHold = hold;
    jumpAddr = ja;
    pcbranch = ba;
    iresp_data = data;
  endtask

  vec_t tbl[26];

  // Reference model state: what the stage holds, in terms of the rules rather than the FSM.
  logic [63:0] m_pc;
  bit          m_have_word;
  logic [31:0] m_word;
  bit          m_fault;
  bit          m_mv, m_mexc;
  logic [63:0] m_mpc;
  logic [31:0] m_minstr;

  task automatic model_load(logic [63:0] a);
    m_mv = 1'b0;
    m_mexc = 1'b0;
    m_pc = a;
    m_have_word = 1'b0;
    m_fault = MIS && (a[1:0] != 2'b00);
  endtask

  initial begin
    tbl[0]  = mk(1,1,0,0,0, 0,0, 1,RPC,1, 1,RPC,0);
    tbl[1]  = mk(1,1,0,0,0, 0,0, 1,64'h8000_0004,1, 1,64'h8000_0004,0);
    tbl[2]  = mk(1,1,0,0,0, 0,0, 1,64'h8000_0008,1, 1,64'h8000_0008,0);
    tbl[3]  = mk(0,0,0,0,0, 0,0, 1,64'h8000_000C,0, 1,64'h8000_0008,0);
    tbl[4]  = mk(0,1,0,0,0, 0,0, 1,64'h8000_000C,1, 1,64'h8000_0008,0);
    tbl[5]  = mk(0,0,0,0,0, 0,0, 0,64'h8000_000C,1, 1,64'h8000_0008,0);
    tbl[6]  = mk(1,0,0,0,0, 0,0, 0,64'h8000_000C,1, 1,64'h8000_000C,0);
    tbl[7]  = mk(1,0,0,0,0, 0,0, 1,64'h8000_0010,0, 0,0,0);
    tbl[8]  = mk(1,1,1,1,0, 64'h8000_0100,64'h8000_0200, 1,64'h8000_0010,1, 0,0,0);
    tbl[9]  = mk(1,0,0,0,0, 0,0, 1,64'h8000_0100,0, 0,0,0);
    tbl[10] = mk(1,1,0,1,0, 0,64'h8000_0300, 1,64'h8000_0100,1, 0,0,0);
    tbl[11] = mk(1,1,0,0,0, 0,0, 1,64'h8000_0300,1, 1,64'h8000_0300,0);
    tbl[12] = mk(0,1,0,0,0, 0,0, 1,64'h8000_0304,1, 1,64'h8000_0300,0);
    tbl[13] = mk(1,0,0,0,1, 0,0, 0,64'h8000_0304,1, 1,64'h8000_0300,0);
    tbl[14] = mk(1,0,0,0,1, 0,0, 0,64'h8000_0304,1, 1,64'h8000_0300,0);
    tbl[15] = mk(1,0,0,0,1, 0,0, 0,64'h8000_0304,1, 1,64'h8000_0300,0);
    tbl[16] = mk(1,0,1,0,1, 64'h8000_0008,0, 0,64'h8000_0304,1, 0,0,0);
    tbl[17] = mk(1,1,0,0,0, 0,0, 1,64'h8000_0008,1, 1,64'h8000_0008,0);
    tbl[18] = mk(1,0,1,0,0, 64'hFFFF_FFFF_FFFF_FFFC,0, 1,64'h8000_000C,0, 0,0,0);
    tbl[19] = mk(1,1,0,0,0, 0,0, 1,64'hFFFF_FFFF_FFFF_FFFC,1, 1,64'hFFFF_FFFF_FFFF_FFFC,0);
    tbl[20] = mk(1,1,0,0,0, 0,0, 1,64'h0,1, 1,64'h0,0);
    tbl[21] = mk(1,1,1,0,0, 64'h8000_0102,0, 1,64'h4,1, 0,0,0);
    tbl[22] = mk(1,1,0,0,0, 0,0, !MIS,64'h8000_0102,1, 1,64'h8000_0102,MIS);
    tbl[23] = mk(1,1,0,0,0, 0,0, !MIS,MIS ? 64'h8000_0102 : 64'h8000_0106,1,
                 1,MIS ? 64'h8000_0102 : 64'h8000_0106,MIS);
    tbl[24] = mk(1,0,1,0,0, 64'h8000_0400,0, !MIS,MIS ? 64'h8000_0102 : 64'h8000_010A,MIS, 0,0,0);
    tbl[25] = mk(1,1,0,0,0, 0,0, 1,64'h8000_0400,1, 1,64'h8000_0400,0);

    rst = 1'b0;
    drive(0,0,0,0,0, 0,0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ireq_valid", ireq_valid, 0);
    chk("reset_addr", ireq_addr, RPC);
    chk("reset_moduleOut", {32'd0, moduleOut}, 0);
    chk("reset_ok", ok_to_proceed, 0);

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 26; i++) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i].ovr, tbl[i].ok, tbl[i].jmp, tbl[i].br, tbl[i].hold, tbl[i].ja, tbl[i].ba,
            tbl[i].ok ? bus_word(tbl[i].e_addr) : $urandom);
      #1;
      chk($sformatf("v%0d_req", i), ireq_valid, tbl[i].e_req);
      chk($sformatf("v%0d_addr", i), ireq_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_ok", i), ok_to_proceed, tbl[i].e_ok);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), moduleOut.valid, tbl[i].e_mv);
      chk($sformatf("v%0d_excv", i), moduleOut.exception_valid, tbl[i].e_mv && tbl[i].e_exc);
      if (tbl[i].e_mv) begin
        chk($sformatf("v%0d_pc", i), moduleOut.pc, tbl[i].e_mpc);
        chk($sformatf("v%0d_pc4", i), moduleOut.pcPlus4, tbl[i].e_mpc + 64'd4);
        chk($sformatf("v%0d_iaddr", i), moduleOut.instrAddr, tbl[i].e_mpc);
        chk($sformatf("v%0d_instr", i), moduleOut.instr,
            tbl[i].e_exc ? 32'd0 : bus_word(tbl[i].e_mpc));
        if (tbl[i].e_exc)
          chk($sformatf("v%0d_exc", i), moduleOut.exception, INSTRUCTION_ADDRESS_MISALIGNED);
      end
    end

    // Reset lands while a request is outstanding and a response is on the bus.
    @(negedge clk);
    rst = 1'b0;
    drive(1,1,0,0,0, 0,0, 32'hDEAD_BEEF);
    #1;
    chk("midrst_req_low", ireq_valid, 0);
    @(posedge clk);
    #1;
    chk("midrst_valid", moduleOut.valid, 0);
    chk("midrst_addr", ireq_addr, RPC);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_req_after", ireq_valid, 1);

    m_pc = RPC; m_have_word = 0; m_word = 0; m_fault = 0;
    m_mv = 0; m_mexc = 0; m_mpc = 0; m_minstr = 0;
    for (int c = 0; c < 400; c++) begin
      bit ovr, ok, jmp, br, hold, e_req, e_ok;
      logic [63:0] ja, ba;
      logic [31:0] data, w;
      if (c != 0) @(negedge clk);
      ovr  = ($urandom_range(0, 3) != 0);
      ok   = ($urandom_range(0, 4) < 3);
      jmp  = ($urandom_range(0, 9) == 0);
      br   = ($urandom_range(0, 9) == 0);
      hold = ($urandom_range(0, 6) == 0);
      ja   = {$urandom, $urandom};
      ba   = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) ja[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) ba[1:0] = 2'b00;
      data = $urandom;
      drive(ovr, ok, jmp, br, hold, ja, ba, data);
      #1;
      e_req = !m_have_word && !m_fault;
      e_ok  = m_have_word || m_fault || (e_req && ok);
      chk("rnd_req", ireq_valid, e_req);
      chk("rnd_addr", ireq_addr, m_pc);
      chk("rnd_ok", ok_to_proceed, e_ok);
      w = m_have_word ? m_word : data;
      if (ovr) begin
        if (jmp) model_load(ja);
        else if (br) model_load(ba);
        else if (hold) begin end
        else if (e_ok) begin
          m_mv = 1'b1;
          m_mpc = m_pc;
          m_mexc = m_fault;
          m_minstr = m_fault ? 32'd0 : w;
          if (!m_fault) begin
            m_pc = m_pc + 64'd4;
            m_have_word = 1'b0;
          end
        end else m_mv = 1'b0;
      end else if (e_req && ok) begin
        m_have_word = 1'b1;
        m_word = data;
      end
      @(posedge clk);
      #1;
      chk("rnd_valid", moduleOut.valid, m_mv);
      chk("rnd_excv", moduleOut.exception_valid, m_mexc);
      if (m_mv) begin
        chk("rnd_pc", moduleOut.pc, m_mpc);
        chk("rnd_pc4", moduleOut.pcPlus4, m_mpc + 64'd4);
        chk("rnd_instr", moduleOut.instr, m_minstr);
      end
      if (m_mexc) chk("rnd_exc", moduleOut.exception, INSTRUCTION_ADDRESS_MISALIGNED);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetcher.md
# fetcher

Instruction-fetch stage: owns the PC, issues single-outstanding requests on the instruction bus, buffers the returned word, and delivers it to the decode stage through the `REG_IF_ID` pipeline register. It applies redirects from the execute stage (`JumpEn`) and from the decoder's branch adoption, and squashes wrong-path fetches. It sits directly upstream of the decoder.

## Interface
- `RESET_PC`, default 64'h8000_0000: PC loaded on reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous and active-low.
- `ireq_valid`  out  1  instruction-bus request valid.
- `ireq_addr`  out  64  request address; always equals the current PC.
- `iresp_ok`  in  1  response valid; meaningful only while `ireq_valid`=1.
- `iresp_data`  in  32  instruction word; valid with `iresp_ok`.
- `moduleOut`  out  `REG_IF_ID`  fields: valid, pc, pcPlus4, instr, instrAddr, exception_valid, exception.
- `ok_to_proceed`  out  1  fetch can hand over an entry this cycle.
- `ok_to_proceed_overall`  in  1  pipeline-wide advance enable.
- `lwHold`  in  1  decoder load-use hold.
- `JumpEn`  in  1  execute-stage redirect.
- `jumpAddr`  in  64  execute-stage redirect target.
- `adopt_branch`  in  1  decoder predicted-taken redirect.
- `pcbranch`  in  64  decoder redirect target.

## Operation
- States: `REQ` (request outstanding), `READY` (word buffered), `EXC` (faulting PC, no bus access; only with the macro).
- `REQ`: `ireq_valid`=1 and `ireq_addr`=pc held stable until `iresp_ok`.
  - `iresp_ok` without advance: latch `iresp_data` into `ibuf`, go to `READY`.
- `READY`: `ireq_valid`=0 and the word is held in `ibuf`.
- `ok_to_proceed` = `READY` | `EXC` | (`REQ` & `iresp_ok`). The word is bypassed from the bus in the `REQ` & `iresp_ok` case.
- **Advance** happens on an edge with `ok_to_proceed_overall`=1. The first matching case applies:
  - `JumpEn`: `moduleOut.valid`<=0, exception_valid<=0, pc<=`jumpAddr`, state<=`REQ`. Any buffered or arriving word is discarded.
  - `adopt_branch`: same as `JumpEn`, with pc<=`pcbranch`.
  - `lwHold`: `moduleOut`, pc, state and `ibuf` are all unchanged.
  - Otherwise: `moduleOut` <= {valid=1, pc, pcPlus4=pc+4, instr=word, instrAddr=pc, exception_valid=0}, pc<=pc+4, state<=`REQ`.
- With `ok_to_proceed_overall`=0: only the `REQ`→`READY` capture may occur. `moduleOut` and pc hold.
- PC arithmetic is modulo 2^64; pc+4 wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0.
- Reset values:
  - state=`REQ`, pc=`RESET_PC`, `ibuf`=0.
  - all `moduleOut` fields 0; valid=0 and exception_valid=0.
  - `ireq_valid` is 0 during reset and 1 on the first cycle after reset is released.
  - Reset asserted with a response pending abandons it; the bus must tolerate abandonment.

## Timing
- Request latency: `ireq_valid` rises the cycle after pc is loaded. There is no combinational path from redirect inputs to `ireq_addr`.
- Best case, a zero-wait bus gives one instruction per cycle via the bypass.
- Each extra bus wait cycle adds one bubble.
- Redirect-to-request: one cycle. The redirect edge emits one bubble (`moduleOut.valid`=0).
- `JumpEn` and `adopt_branch` in the same cycle: `JumpEn` wins.
- A redirect coinciding with `lwHold` is still taken.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - When pc[1:0]≠0 after any pc load, state<=`EXC` and no bus request is made.
  - On advance, `moduleOut` gets exception_valid=1, exception=`INSTRUCTION_ADDRESS_MISALIGNED`, valid=1, instr=0, pc=faulting pc.
  - pc then holds until a redirect arrives.
- Not defined: pc[1:0] is ignored, `EXC` does not exist, and the bus sees the raw address.

## Structure
- `common` package: `REG_IF_ID`, exception enum (including `INSTRUCTION_ADDRESS_MISALIGNED`), `fetch_state_t` {REQ, READY, EXC}.
- Sub-module `fetch_pc_sel`: combinational next-pc priority mux (jump, branch, hold, sequential). All state stays in `fetcher`.

## Test plan
- **Reset, zero-wait bus:** release `rst`, `iresp_ok`=1 every cycle -> `ireq_addr` 8000_0000, 8000_0004, 8000_0008 on consecutive cycles; `moduleOut.valid`=1 each edge from the second edge on.
- **Two-cycle bus wait:** `iresp_ok` at 8000_0000 arrives after 2 cycles with `ok_to_proceed_overall`=0 -> state `READY`, `ibuf`=word, `ireq_valid`=0. Raising `ok_to_proceed_overall` then delivers the word.
- **`JumpEn` and `adopt_branch` together:** `jumpAddr`=8000_0100, `pcbranch`=8000_0200 -> bubble emitted, next `ireq_addr`=8000_0100.
- **`lwHold` for 3 cycles:** `moduleOut` stable; pc stays 8000_0008; no new request after the buffered word.
- **Misalign check (macro defined):** `jumpAddr`=8000_0102 -> `ireq_valid` stays 0; next advance shows exception_valid=1, exception=`INSTRUCTION_ADDRESS_MISALIGNED`, pc=8000_0102.
- **Reset mid-request:** drop `rst` while in `REQ` -> next cycle pc=`RESET_PC`, `moduleOut.valid`=0, state `REQ`.
